// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage fetch-PC generator with valid/ready issue, EX redirects and an accept counter.
// Optional MISALIGN_TRAP_EN: misaligned redirects pulse misaligned_err and vector to TRAP_VECTOR.
module fetch_pc_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned     CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   input  logic             imem_ready,
   output logic [XLEN-1:0]  pc,
   output logic             pc_valid,
   output logic [XLEN-1:0]  next_pc,
   output logic [CNT_W-1:0] fetch_count,
   output logic             misaligned_err
);

   if (RESET_VECTOR[1:0] != 2'b00 || TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_vector
      $error("fetch_pc_unit: reset and trap vectors must be word aligned");
   end

`ifdef MISALIGN_TRAP_EN
   typedef enum logic [1:0] {BOOT, FETCH, TRAP} state_t;
`else
   typedef enum logic [1:0] {BOOT, FETCH} state_t;
`endif

   state_t state, state_next;
   logic   accept;
   logic   trap_load;

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      next_pc    = pc;
      pc_valid   = 1'b0;

      case (state)
         BOOT:    state_next = FETCH;
         FETCH:   pc_valid   = !stall;
`ifdef MISALIGN_TRAP_EN
         TRAP:    state_next = FETCH;
`endif
         default: state_next = BOOT;
      endcase

      accept = pc_valid & imem_ready;

`ifdef MISALIGN_TRAP_EN
      trap_load = (state == TRAP);
`else
      trap_load = 1'b0;
`endif

      // The trap vector load owns the TRAP exit edge; redirect outranks stall and accept.
      if (trap_load) begin
         next_pc = TRAP_VECTOR;
      end else if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
         next_pc = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) state_next = TRAP;
`else
         next_pc = redirect_pc & ~XLEN'(3);
`endif
      end else if (accept) begin
         next_pc = pc + XLEN'(4);
      end
   end

   assign misaligned_err = trap_load;

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= BOOT;
         pc          <= RESET_VECTOR;
         fetch_count <= '0;
      end else begin
         state <= state_next;
         pc    <= next_pc;
         if (accept) fetch_count <= fetch_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed spec scenarios plus random traffic, checked by a scoreboard
// against a transaction-level model of the fetch-PC rules.
module tb_fetch_pc_unit;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, redirect_valid, imem_ready;
   logic [31:0] redirect_pc;
   logic [31:0] pc, next_pc, fetch_count;
   logic        pc_valid, misaligned_err;

   fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_ready(imem_ready), .pc(pc), .pc_valid(pc_valid),
      .next_pc(next_pc), .fetch_count(fetch_count), .misaligned_err(misaligned_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] npc;
      logic        err;
      logic [31:0] cnt;
   } rec_t;

   rec_t        cyc_q[$];
   logic [31:0] tx_q[$];
   int          checks = 0;
   int          errors = 0;

   // Reference model: where the fetch stream is and how many fetches have been accepted.
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   bit          m_boot;
   bit          m_trap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs (called at posedge+1), predict the cycle, advance the model.
   task automatic step(input bit s, input bit rv, input logic [31:0] rpc, input bit rdy);
      rec_t        r;
      bit          issuing, acc, go_trap;
      logic [31:0] target;
      stall = s; redirect_valid = rv; redirect_pc = rpc; imem_ready = rdy;
      issuing = !m_boot && !m_trap && !s;
      acc     = issuing && rdy;
      go_trap = 1'b0;
      if (m_trap) target = TV;
      else if (rv) begin
`ifdef MISALIGN_TRAP_EN
         target  = rpc;
         go_trap = (rpc % 4) != 0;
`else
         target  = rpc - (rpc % 4);
`endif
      end else if (acc) target = m_pc + 32'd4;
      else target = m_pc;
      r.pc = m_pc; r.valid = issuing; r.npc = target; r.err = m_trap; r.cnt = m_cnt;
      cyc_q.push_back(r);
      if (acc) tx_q.push_back(m_pc);
      m_cnt  = m_cnt + (acc ? 32'd1 : 32'd0);
      m_pc   = target;
      m_boot = 1'b0;
      m_trap = go_trap;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rec_t r;
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
      #1;
      check("rst_pc", pc, RV);
      check("rst_cnt", fetch_count, 32'd0);
      check("rst_valid", {31'd0, pc_valid}, 32'd0);
      check("rst_err", {31'd0, misaligned_err}, 32'd0);
      m_pc = RV; m_cnt = 0; m_boot = 1'b1; m_trap = 1'b0;
      r.pc = RV; r.valid = 1'b0; r.npc = RV; r.err = 1'b0; r.cnt = 0;
      cyc_q.push_back(r);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   // Monitor: per-cycle status against the cycle queue, handshakes against the transaction queue.
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         if (cyc_q.size() > 0) begin
            r = cyc_q.pop_front();
            check("pc", pc, r.pc);
            check("pc_valid", {31'd0, pc_valid}, {31'd0, r.valid});
            check("next_pc", next_pc, r.npc);
            check("misaligned_err", {31'd0, misaligned_err}, {31'd0, r.err});
            check("fetch_count", fetch_count, r.cnt);
         end
         if (rst && pc_valid && imem_ready) begin
            if (tx_q.size() == 0) check("unexpected_fetch", pc, 32'hDEAD_BEEF);
            else check("fetch_addr", pc, tx_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] c0;
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // 1: boot bubble, then 0x0, 0x4, 0x8 accepted
      for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
      check("t1_pc", pc, 32'h0000_000C);
      check("t1_cnt", fetch_count, 32'd3);

      // 2: imem not ready for 3 cycles at 0x10
      step(0, 1, 32'h10, 0);
      for (int i = 0; i < 3; i++) step(0, 0, '0, 0);
      check("t2_hold_pc", pc, 32'h10);
      check("t2_hold_valid", {31'd0, pc_valid}, 32'd1);
      step(0, 0, '0, 1);
      check("t2_adv_pc", pc, 32'h14);

      // 3: stall for 2 cycles at 0x20
      step(0, 1, 32'h20, 0);
      c0 = fetch_count;
      step(1, 0, '0, 1);
      step(1, 0, '0, 1);
      check("t3_stall_pc", pc, 32'h20);
      check("t3_stall_valid", {31'd0, pc_valid}, 32'd0);
      check("t3_stall_cnt", fetch_count, c0);
      step(0, 0, '0, 1);
      check("t3_resume_pc", pc, 32'h24);

      // 4: redirect alongside an accept at 0x30, then alongside a stall
      step(0, 1, 32'h30, 0);
      c0 = fetch_count;
      step(0, 1, 32'h400, 1);
      check("t4_redir_pc", pc, 32'h400);
      check("t4_redir_cnt", fetch_count, c0 + 32'd1);
      step(1, 1, 32'h500, 1);
      check("t4_stall_redir_pc", pc, 32'h500);
      check("t4_stall_redir_cnt", fetch_count, c0 + 32'd1);

      // 5: wrap of pc + 4
      step(0, 1, 32'hFFFF_FFFC, 0);
      step(0, 0, '0, 1);
      check("t5_wrap_pc", pc, 32'h0);

      // 6: misaligned redirect
      step(0, 1, 32'h402, 0);
`ifdef MISALIGN_TRAP_EN
      check("t6_err_pulse", {31'd0, misaligned_err}, 32'd1);
      step(0, 0, '0, 0);
      check("t6_trap_pc", pc, 32'h100);
      check("t6_err_clear", {31'd0, misaligned_err}, 32'd0);
`else
      check("t6_aligned_pc", pc, 32'h400);
      check("t6_no_err", {31'd0, misaligned_err}, 32'd0);
`endif

      // Reset mid-handshake
      step(0, 0, '0, 1);
      step(0, 0, '0, 1);
      do_reset();

      // Random traffic with occasional mid-stream resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom,
                   $urandom_range(0, 3) != 0);
      end

      @(negedge clk); #1;
      check("cycle_queue_drained", cyc_q.size(), 32'd0);
      check("fetch_queue_drained", tx_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
